// File: rtl/distance_ctrl_pkg.sv
// Shared types, 7-segment table and saturating-subtract helper for distance_motor_ctrl.
package distance_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARM      = 2'd1,
    RUN      = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  localparam logic [6:0] SEG7_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // a - b floored at zero, then clamped to the largest value representable in w bits.
  function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [31:0] diff;
    logic [31:0] lim;
    diff = (a > b) ? (a - b) : 32'd0;
    lim  = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (diff > lim) ? lim : diff;
  endfunction

endpackage

// File: rtl/distance_motor_ctrl_seg7.sv
// Combinational hex to 7-segment encoder (seg[0]=a .. seg[6]=g, active-high).
module seg7_encoder
  import distance_ctrl_pkg::*;
(
  input  logic [3:0] i_value,
  output logic [6:0] o_seg
);

  assign o_seg = SEG7_HEX[i_value];

endmodule

// File: rtl/distance_motor_ctrl.sv
// Distance threshold motor controller: confirm/hysteresis/cooldown FSM, saturated excess, 7-seg.
// Optional 4-sample distance averaging is enabled by defining DIST_AVG_EN.
module distance_motor_ctrl
  import distance_ctrl_pkg::*;
#(
  parameter int DIST_W  = 5,
  parameter int EXC_W   = 3,
  parameter int CONFIRM = 3,
  parameter int HYST    = 2,
  parameter int MIN_OFF = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_valid,
  input  logic [DIST_W-1:0] distance,
  input  logic [DIST_W-1:0] threshold,
  output logic              motor_sig,
  output logic [EXC_W-1:0]  excess,
  output logic [6:0]        seg
);

  localparam int CMP_W  = DIST_W + 1;
  localparam int CNT_W  = $clog2(CONFIRM + 1);
  localparam int COOL_W = $clog2(MIN_OFF + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(CONFIRM);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [COOL_W-1:0] COOL_LAST = COOL_W'(MIN_OFF - 1);

  logic [DIST_W-1:0] w_d;
  logic [DIST_W-1:0] w_thr;
  logic              w_valid;

`ifdef DIST_AVG_EN
  logic [DIST_W-1:0] r_hist [3];
  logic [DIST_W-1:0] r_avg_d;
  logic [DIST_W-1:0] r_avg_thr;
  logic              r_avg_valid;
  logic [DIST_W+1:0] w_sum;

  assign w_sum = (DIST_W+2)'(distance) + (DIST_W+2)'(r_hist[0])
               + (DIST_W+2)'(r_hist[1]) + (DIST_W+2)'(r_hist[2]);

  // History only shifts on valid samples; threshold travels with its average.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) r_hist[k] <= '0;
      r_avg_d     <= '0;
      r_avg_thr   <= '0;
      r_avg_valid <= 1'b0;
    end else begin
      r_avg_valid <= sample_valid;
      if (sample_valid) begin
        r_hist[0] <= distance;
        for (int k = 1; k < 3; k++) r_hist[k] <= r_hist[k-1];
        r_avg_d   <= DIST_W'(w_sum >> 2);
        r_avg_thr <= threshold;
      end
    end
  end

  assign w_d     = r_avg_d;
  assign w_thr   = r_avg_thr;
  assign w_valid = r_avg_valid;
`else
  assign w_d     = distance;
  assign w_thr   = threshold;
  assign w_valid = sample_valid;
`endif

  logic [CMP_W-1:0] w_d_ext;
  logic [CMP_W-1:0] w_thr_ext;
  logic [CMP_W-1:0] w_rel_ext;
  logic             w_over;
  logic             w_under;

  assign w_d_ext   = CMP_W'(w_d);
  assign w_thr_ext = CMP_W'(w_thr);
  assign w_rel_ext = CMP_W'(sat_sub(32'(w_thr_ext), 32'(HYST), CMP_W));
  assign w_over    = (w_d_ext > w_thr_ext);
  assign w_under   = (w_d_ext <= w_rel_ext);

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [COOL_W-1:0] r_cool;
  logic [COOL_W-1:0] w_cool_next;
  logic              r_motor;
  logic [EXC_W-1:0]  r_excess;
  logic [EXC_W-1:0]  w_excess_next;

  assign w_cnt_inc = (r_cnt >= CNT_MAX) ? CNT_MAX : (r_cnt + CNT_ONE);

  assign w_excess_next = w_valid ? EXC_W'(sat_sub(32'(w_d_ext), 32'(w_thr_ext), EXC_W))
                                 : r_excess;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cool_next  = r_cool;
    unique case (r_state)
      IDLE: begin
        if (w_valid && w_over) begin
          if (CONFIRM == 1) begin
            w_state_next = RUN;
            w_cnt_next   = '0;
          end else begin
            w_state_next = ARM;
            w_cnt_next   = CNT_ONE;
          end
        end
      end
      ARM: begin
        if (w_valid) begin
          if (!w_over) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
          end else if (w_cnt_inc == CNT_MAX) begin
            w_state_next = RUN;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next   = w_cnt_inc;
          end
        end
      end
      RUN: begin
        // Anything above the release level breaks the under streak but keeps RUN.
        if (w_valid) begin
          if (!w_under) begin
            w_cnt_next   = '0;
          end else if (w_cnt_inc == CNT_MAX) begin
            w_state_next = COOLDOWN;
            w_cnt_next   = '0;
            w_cool_next  = '0;
          end else begin
            w_cnt_next   = w_cnt_inc;
          end
        end
      end
      COOLDOWN: begin
        if (r_cool == COOL_LAST) begin
          w_state_next = IDLE;
          w_cnt_next   = '0;
          w_cool_next  = '0;
        end else begin
          w_cool_next  = r_cool + COOL_W'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
        w_cnt_next   = '0;
        w_cool_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_cool   <= '0;
      r_motor  <= 1'b0;
      r_excess <= '0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_cool   <= w_cool_next;
      r_motor  <= (w_state_next == RUN);
      r_excess <= w_excess_next;
    end
  end

  logic [3:0] w_exc4;
  assign w_exc4 = 4'(r_excess);

  seg7_encoder u_seg7 (
    .i_value (w_exc4),
    .o_seg   (seg)
  );

  assign motor_sig = r_motor;
  assign excess    = r_excess;

endmodule

// File: tb/tb_distance_motor_ctrl.sv
// Self-checking bench for distance_motor_ctrl: streak/cooldown reference model plus directed literals.
module tb_distance_motor_ctrl;

  localparam int DIST_W  = 5;
  localparam int EXC_W   = 3;
  localparam int CONFIRM = 3;
  localparam int HYST    = 2;
  localparam int MIN_OFF = 8;
  localparam int EXC_MAX = (1 << EXC_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sample_valid = 1'b0;
  logic [DIST_W-1:0] distance = '0;
  logic [DIST_W-1:0] threshold = 5'd10;
  logic              motor_sig;
  logic [EXC_W-1:0]  excess;
  logic [6:0]        seg;

  distance_motor_ctrl #(
    .DIST_W (DIST_W), .EXC_W (EXC_W), .CONFIRM (CONFIRM),
    .HYST (HYST), .MIN_OFF (MIN_OFF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .distance     (distance),
    .threshold    (threshold),
    .motor_sig    (motor_sig),
    .excess       (excess),
    .seg          (seg)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  logic [6:0] seg_tab [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Reference model: streak counts of over/under samples and a cooldown timer.
  bit m_run;
  int m_over_streak, m_under_streak, m_cool_left, m_excess;
`ifdef DIST_AVG_EN
  int hist[$];
  bit p_valid;
  int p_d, p_thr;
`endif

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_run = 0; m_over_streak = 0; m_under_streak = 0; m_cool_left = 0; m_excess = 0;
`ifdef DIST_AVG_EN
    hist = '{0, 0, 0};
    p_valid = 0; p_d = 0; p_thr = 0;
`endif
  endfunction

  function automatic void fsm_step(bit v, int d, int thr);
    int rel;
    bit over, under;
    rel   = (thr > HYST) ? thr - HYST : 0;
    over  = d > thr;
    under = d <= rel;
    if (v) m_excess = over ? (((d - thr) > EXC_MAX) ? EXC_MAX : d - thr) : 0;
    if (m_cool_left > 0) begin
      m_cool_left--;
    end else if (!m_run) begin
      if (v) begin
        m_over_streak = over ? m_over_streak + 1 : 0;
        if (m_over_streak >= CONFIRM) begin
          m_run = 1; m_over_streak = 0; m_under_streak = 0;
        end
      end
    end else if (v) begin
      m_under_streak = under ? m_under_streak + 1 : 0;
      if (m_under_streak >= CONFIRM) begin
        m_run = 0; m_under_streak = 0; m_cool_left = MIN_OFF;
      end
    end
  endfunction

  function automatic void model_edge(bit v, int d, int thr);
`ifdef DIST_AVG_EN
    fsm_step(p_valid, p_d, p_thr);
    p_valid = v;
    if (v) begin
      p_d   = (d + hist[0] + hist[1] + hist[2]) >> 2;
      p_thr = thr;
      hist.push_front(d);
      void'(hist.pop_back());
    end
`else
    fsm_step(v, d, thr);
`endif
  endfunction

  // One clock edge of stimulus; outputs are checked against the model on the following negedge.
  task automatic drive(input bit v, input int d, input int thr);
    sample_valid = v;
    distance     = DIST_W'(d);
    threshold    = DIST_W'(thr);
    @(posedge clk);
    model_edge(v, d, thr);
    #1;
    sample_valid = 1'b0;
    if (v) $display("sample d=%0d thr=%0d exp motor=%0d excess=%0d", d, thr, m_run, m_excess);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 10);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_motor", motor_sig, 0);
    check("reset_excess", excess, 0);
    check("reset_seg", seg, 7'h3F);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
  endtask

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("model_motor", motor_sig, m_run);
      check("model_excess", excess, m_excess);
      check("model_seg", seg, seg_tab[m_excess]);
    end
  end

  initial begin
    model_reset();
    do_reset();

`ifndef DIST_AVG_EN
    // Trip after three over samples
    drive(1, 12, 10); drive(1, 12, 10);
    check("pre_trip_motor", motor_sig, 0);
    drive(1, 12, 10);
    check("trip_motor", motor_sig, 1);
    check("trip_excess", excess, 2);
    check("trip_seg", seg, 7'h5B);
    drive(1, 20, 10);
    check("sat_excess", excess, 7);
    check("sat_seg", seg, 7'h07);
    // Hysteresis band holds RUN, then release and cooldown
    drive(1, 9, 10); drive(1, 9, 10); drive(1, 9, 10);
    check("band_motor", motor_sig, 1);
    drive(1, 8, 10); drive(1, 8, 10);
    check("release_pending", motor_sig, 1);
    drive(1, 8, 10);
    check("release_motor", motor_sig, 0);
    for (int i = 0; i < MIN_OFF; i++) drive(1, 15, 10);
    check("cooldown_motor", motor_sig, 0);
    check("cooldown_excess", excess, 5);
    drive(1, 15, 10); drive(1, 15, 10); drive(1, 15, 10);
    check("retrip_motor", motor_sig, 1);
    // Asynchronous reset during RUN
    drive(0, 0, 10);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_motor", motor_sig, 0);
    check("async_excess", excess, 0);
    check("async_seg", seg, 7'h3F);
    do_reset();
    // Broken over streak
    drive(1, 12, 10); drive(1, 12, 10); drive(1, 5, 10); drive(1, 12, 10); drive(1, 12, 10);
    check("abort_motor", motor_sig, 0);
    drive(1, 12, 10);
    check("abort_retrip", motor_sig, 1);
`else
    drive(1, 12, 10); drive(1, 12, 10); drive(1, 12, 10);
    idle(1);
    check("avg3_excess", excess, 0);
    drive(1, 12, 10);
    idle(1);
    check("avg4_excess", excess, 2);
    check("avg4_motor", motor_sig, 0);
`endif

    // Randomized stimulus around the threshold
    do_reset();
    begin
      int thr, d;
      thr = 10;
      for (int n = 0; n < 600; n++) begin
        if ($urandom_range(0, 24) == 0) thr = $urandom_range(0, 31);
        d = thr + $urandom_range(0, 10) - 5;
        if ($urandom_range(0, 15) == 0) d = $urandom_range(0, 31);
        if (d < 0) d = 0;
        if (d > 31) d = 31;
        drive($urandom_range(0, 9) < 6, d, thr);
      end
    end

    idle(2);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
